l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Two-requester arbiter sharing the single L2 cache port between the L1 instruction cache (read-only line fills) and the L1 data cache (line fills and dirty write-backs).
- Sits between the L1 caches and the L2 cache request interface (address, read/write, byte enable, 256-bit line data, resp).
- Grants one whole transaction at a time, with round-robin fairness under contention.
- Provides saturating grant and contention counters for performance analysis.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width in bits.
- OFFSET_W, 5, line-offset bits; forced to zero on the L2 address.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_addr  in  ADDR_W  I-cache request address
- i_read  in  1  I-cache line read request
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache transaction done, one-cycle pulse
- d_addr  in  ADDR_W  D-cache request address
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write-back request
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache transaction done, one-cycle pulse
- l2_address  out  ADDR_W  L2 request address, line aligned
- l2_read  out  1  L2 read request
- l2_write  out  1  L2 write request
- l2_byte_enable  out  8  always 8'hFF while a request is active; 0 otherwise
- l2_wdata  out  LINE_W  L2 write line
- l2_rdata  in  LINE_W  L2 read line
- l2_resp  in  1  L2 transaction done
- i_grant_cnt  out  CNT_W  I-side grants, saturating
- d_grant_cnt  out  CNT_W  D-side grants, saturating
- conflict_cnt  out  CNT_W  cycles where both requesters waited in IDLE, saturating

Behaviour:
- Reset: async, active-high, takes effect immediately.
  - State goes to IDLE and last_grant goes to I, so D wins the first tie.
  - All counters clear to 0.
  - l2_read, l2_write, i_resp and d_resp are 0 during reset and in the cycle after.
  - Reset mid-transaction abandons it with no resp to the requester. The L2 side is reset by the same rst.
- States: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE: no L2 request is driven; l2_address = 0 and l2_wdata = 0.
  - Pending requests: pi = i_read; pd = d_read | d_write.
  - pi only -> GRANT_I. pd only -> GRANT_D.
  - Both pending -> grant the side not equal to last_grant, and increment conflict_cnt.
- Latching at the grant edge: {addr[ADDR_W-1:OFFSET_W], 0} is latched, plus the op (read/write).
  - d_read & d_write both high -> treated as write.
  - last_grant and the matching grant counter update.
- GRANT_x: drives l2_address from the latched address, l2_read/l2_write from the latched op, and l2_byte_enable = 8'hFF.
  - l2_wdata is taken combinationally from d_wdata in GRANT_D and is 0 in GRANT_I.
  - The D-cache must hold d_wdata stable until d_resp.
  - The request stays asserted until l2_resp, even if the requester drops its request (a requester drop is a protocol violation; the arbiter completes the transaction anyway).
- Completion, on the cycle l2_resp = 1 in GRANT_x:
  - x_resp = 1 combinationally in that same cycle.
  - x_rdata = l2_rdata; the other side's rdata is 0 and its resp is 0.
  - Next state is DONE.
- DONE: one cycle with l2_read = l2_write = 0 so L2 control observes the deassertion, then return to IDLE.
- Throughput and latency:
  - Minimum arbitration overhead is 1 cycle (IDLE->GRANT) plus 1 cycle (DONE).
  - Back-to-back transactions are separated by at least 2 cycles without an L2 request.
- l2_resp outside GRANT_x is ignored.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package: arb_state_t enum {IDLE, GRANT_I, GRANT_D, DONE}, requester_t {REQ_I, REQ_D}, LINE_W and OFFSET_W constants shared with the L2 cache.
- One sub-module: sat_counter (CNT_W param, inc input, async rst), instanced three times.
- FSM and muxing stay in l2_arbiter.

Test Plan:
- I only: i_read=1, i_addr=0x0000_1234, L2 replies after 3 cycles with rdata=A -> l2_address=0x0000_1220, l2_read held 3 cycles, i_resp pulses once with i_rdata=A, DONE cycle shows l2_read=0, i_grant_cnt=1.
- Simultaneous after reset: i_read and d_read asserted in the same cycle -> D granted first, then I; conflict_cnt=1 (I is still pending alone after D completes), both grant counts=1.
- Sustained contention: both requesting continuously for 4 transactions -> grant order D,I,D,I; no side served twice in a row.
- Write-back: d_write=1, d_addr=0x8000_0040, d_wdata=W -> l2_write=1, l2_wdata=W, l2_byte_enable=8'hFF until l2_resp; d_resp pulses; i_resp stays 0.
- Reset mid-transaction: rst pulsed in GRANT_I before l2_resp -> l2_read drops immediately, no i_resp, counters read 0, next request granted normally.
- Illegal d_read&d_write and requester drop: -> write issued, request held until l2_resp, exactly one d_resp.

Source files
------------

// File: rtl/l2_arbiter_pkg.sv
// Shared types and line geometry for the L1/L2 arbitration path.
// Line width and offset constants must match the L2 cache.
package l2_arbiter_pkg;

  localparam int L2_LINE_W   = 256;
  localparam int L2_OFFSET_W = 5;
  localparam int L2_BE_W     = 8;
  localparam logic [L2_BE_W-1:0] L2_BE_ALL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/l2_arbiter_sat_counter.sv
// Saturating event counter: increments on i_inc, holds at all-ones, clears on rst.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter giving the I-cache or D-cache one whole L2 transaction at a time.
// Grant one cycle after request, request held until l2_resp, then one DONE cycle; losers wait in IDLE.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = L2_LINE_W,
  parameter int OFFSET_W = L2_OFFSET_W,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_read,
  output logic [LINE_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [LINE_W-1:0]   d_wdata,
  output logic [LINE_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic [ADDR_W-1:0]   l2_address,
  output logic                l2_read,
  output logic                l2_write,
  output logic [L2_BE_W-1:0]  l2_byte_enable,
  output logic [LINE_W-1:0]   l2_wdata,
  input  logic [LINE_W-1:0]   l2_rdata,
  input  logic                l2_resp,
  output logic [CNT_W-1:0]    i_grant_cnt,
  output logic [CNT_W-1:0]    d_grant_cnt,
  output logic [CNT_W-1:0]    conflict_cnt
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  arb_state_t         r_state;
  requester_t         r_last;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_l2_read;
  logic               r_l2_write;

  logic w_pi;
  logic w_pd;
  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_conflict;

  assign w_pi   = i_read;
  assign w_pd   = d_read | d_write;
  assign w_idle = (r_state == IDLE);

  // On a tie the side that did not win last time takes the grant.
  assign w_grant_d  = w_idle && w_pd && (!w_pi || (r_last == REQ_I));
  assign w_grant_i  = w_idle && w_pi && (!w_pd || (r_last == REQ_D));
  assign w_conflict = w_idle && w_pi && w_pd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= REQ_I;
      r_addr     <= '0;
      r_l2_read  <= 1'b0;
      r_l2_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state    <= GRANT_D;
            r_last     <= REQ_D;
            r_addr     <= d_addr & ALIGN_MASK;
            r_l2_write <= d_write;
            r_l2_read  <= ~d_write;
          end else if (w_grant_i) begin
            r_state    <= GRANT_I;
            r_last     <= REQ_I;
            r_addr     <= i_addr & ALIGN_MASK;
            r_l2_write <= 1'b0;
            r_l2_read  <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (l2_resp) begin
            r_state    <= DONE;
            r_addr     <= '0;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_addr     <= '0;
          r_l2_read  <= 1'b0;
          r_l2_write <= 1'b0;
        end
      endcase
    end
  end

  assign l2_address     = r_addr;
  assign l2_read        = r_l2_read;
  assign l2_write       = r_l2_write;
  assign l2_byte_enable = (r_l2_read | r_l2_write) ? L2_BE_ALL : '0;
  assign l2_wdata       = (r_state == GRANT_D) ? d_wdata : '0;

  // Completion is signalled in the same cycle L2 reports it.
  assign i_resp  = (r_state == GRANT_I) && l2_resp;
  assign d_resp  = (r_state == GRANT_D) && l2_resp;
  assign i_rdata = i_resp ? l2_rdata : '0;
  assign d_rdata = d_resp ? l2_rdata : '0;

  sat_counter #(.CNT_W(CNT_W)) u_i_grant_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_grant_i),
    .o_cnt (i_grant_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_grant_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_grant_d),
    .o_cnt (d_grant_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_conflict),
    .o_cnt (conflict_cnt)
  );

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: directed requests, a latency-programmable L2 model,
// and monitors checking every L2 request and every requester response.
module tb_l2_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_addr;
  logic          i_read;
  logic [255:0]  i_rdata;
  logic          i_resp;
  logic [31:0]   d_addr;
  logic          d_read;
  logic          d_write;
  logic [255:0]  d_wdata;
  logic [255:0]  d_rdata;
  logic          d_resp;
  logic [31:0]   l2_address;
  logic          l2_read;
  logic          l2_write;
  logic [7:0]    l2_byte_enable;
  logic [255:0]  l2_wdata;
  logic [255:0]  l2_rdata;
  logic          l2_resp;
  logic [31:0]   i_grant_cnt;
  logic [31:0]   d_grant_cnt;
  logic [31:0]   conflict_cnt;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_addr         (i_addr),
    .i_read         (i_read),
    .i_rdata        (i_rdata),
    .i_resp         (i_resp),
    .d_addr         (d_addr),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_resp         (d_resp),
    .l2_address     (l2_address),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_byte_enable (l2_byte_enable),
    .l2_wdata       (l2_wdata),
    .l2_rdata       (l2_rdata),
    .l2_resp        (l2_resp),
    .i_grant_cnt    (i_grant_cnt),
    .d_grant_cnt    (d_grant_cnt),
    .conflict_cnt   (conflict_cnt)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    int           len;
  } req_t;

  typedef struct {
    logic         side;   // 0 = I, 1 = D
    logic [255:0] data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [255:0] W1 = {8{32'hDEAD_0001}};
  localparam logic [255:0] W2 = {8{32'hBEEF_0002}};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [255:0] rd_of(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_5A5A}};
  endfunction

  task automatic push_req(input logic [31:0] a, input logic wr, input logic [255:0] wd,
                          input int len, input logic side);
    req_t  r;
    resp_t p;
    r.addr = a; r.wr = wr; r.wdata = wd; r.len = len;
    p.side = side; p.data = rd_of(a);
    req_q.push_back(r);
    resp_q.push_back(p);
  endtask

  // L2 model: answers after lat request cycles with data derived from the address it sees.
  int lat = 3;
  int m_cnt = 0;
  initial begin
    l2_resp  = 1'b0;
    l2_rdata = '0;
  end
  always @(posedge clk) begin
    #1;
    if (rst || !(l2_read || l2_write)) begin
      m_cnt   = 0;
      l2_resp = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt == lat) begin
        l2_resp  = 1'b1;
        l2_rdata = rd_of(l2_address);
        m_cnt    = 0;
      end else begin
        l2_resp = 1'b0;
      end
    end
  end

  // Monitor: L2 request side and requester responses.
  logic m_active = 1'b0;
  int   m_len = 0;
  int   m_gap = 99;
  req_t m_cur;
  always @(negedge clk) begin
    logic  act;
    resp_t p;
    if (rst) begin
      m_active = 1'b0;
      m_gap    = 99;
    end else begin
      act = l2_read | l2_write;
      if (act && !m_active) begin
        chk("l2 request expected", req_q.size() != 0, 1'b1);
        if (req_q.size() != 0) begin
          m_cur = req_q.pop_front();
          chk("l2_address", l2_address, m_cur.addr);
          chk("l2_write", l2_write, m_cur.wr);
          chk("l2_read", l2_read, !m_cur.wr);
          chk("l2_wdata start", l2_wdata, m_cur.wdata);
          chk("idle gap >= 2", m_gap >= 2, 1'b1);
        end
        m_len = 0;
        m_gap = 0;
      end
      if (act) begin
        m_len++;
        chk("l2_byte_enable active", l2_byte_enable, 8'hFF);
        if (l2_resp) begin
          chk("request length", m_len, m_cur.len);
          chk("l2_wdata at resp", l2_wdata, m_cur.wdata);
        end
      end else begin
        m_gap++;
        chk("idle l2_address", l2_address, 32'h0);
        chk("idle l2_wdata", l2_wdata, 256'h0);
        chk("idle l2_byte_enable", l2_byte_enable, 8'h00);
      end
      m_active = act;

      if (i_resp || d_resp) begin
        chk("resp one side only", i_resp & d_resp, 1'b0);
        chk("resp with l2_resp", l2_resp, 1'b1);
        chk("resp expected", resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
          p = resp_q.pop_front();
          chk("resp side", d_resp, p.side);
          if (d_resp) begin
            chk("d_rdata", d_rdata, p.data);
            chk("i_rdata idle side", i_rdata, 256'h0);
          end else begin
            chk("i_rdata", i_rdata, p.data);
            chk("d_rdata idle side", d_rdata, 256'h0);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req_i(input logic [31:0] a);
    logic got = 1'b0;
    i_addr = a;
    i_read = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = i_resp;
    end
    chk("i_resp seen", got, 1'b1);
    tick(1);
    i_read = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] a, input logic wr, input logic rd, input logic [255:0] wd);
    logic got = 1'b0;
    d_addr  = a;
    d_read  = rd;
    d_write = wr;
    d_wdata = wd;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = d_resp;
    end
    chk("d_resp seen", got, 1'b1);
    tick(1);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst l2_read", l2_read, 1'b0);
    chk("rst l2_write", l2_write, 1'b0);
    chk("rst i_resp", i_resp, 1'b0);
    chk("rst d_resp", d_resp, 1'b0);
    tick(2);
    chk("rst i_grant_cnt", i_grant_cnt, 32'd0);
    chk("rst d_grant_cnt", d_grant_cnt, 32'd0);
    chk("rst conflict_cnt", conflict_cnt, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("post-rst l2_read", l2_read, 1'b0);
    chk("post-rst i_resp", i_resp, 1'b0);
    chk("post-rst d_resp", d_resp, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    tick(1);
    do_reset();

    // I only: aligned address, 3-cycle L2 latency.
    push_req(32'h0000_1220, 1'b0, 256'h0, 3, 1'b0);
    req_i(32'h0000_1234);
    tick(3);
    chk("T1 i_grant_cnt", i_grant_cnt, 32'd1);
    chk("T1 d_grant_cnt", d_grant_cnt, 32'd0);
    chk("T1 conflict_cnt", conflict_cnt, 32'd0);

    // Simultaneous after reset: D wins first, then I.
    do_reset();
    push_req(32'h0000_2000, 1'b0, 256'h0, 3, 1'b1);
    push_req(32'h0000_3000, 1'b0, 256'h0, 3, 1'b0);
    fork
      req_d(32'h0000_2008, 1'b0, 1'b1, 256'h0);
      req_i(32'h0000_3010);
    join
    tick(3);
    chk("T2 conflict_cnt", conflict_cnt, 32'd1);
    chk("T2 i_grant_cnt", i_grant_cnt, 32'd1);
    chk("T2 d_grant_cnt", d_grant_cnt, 32'd1);

    // Sustained contention: D,I,D,I (last I request is alone).
    push_req(32'h0000_4000, 1'b0, 256'h0, 3, 1'b1);
    push_req(32'h0000_5000, 1'b0, 256'h0, 3, 1'b0);
    push_req(32'h0000_4100, 1'b0, 256'h0, 3, 1'b1);
    push_req(32'h0000_5100, 1'b0, 256'h0, 3, 1'b0);
    fork
      begin
        req_d(32'h0000_4004, 1'b0, 1'b1, 256'h0);
        req_d(32'h0000_4104, 1'b0, 1'b1, 256'h0);
      end
      begin
        req_i(32'h0000_5008);
        req_i(32'h0000_5108);
      end
    join
    tick(3);
    chk("T3 conflict_cnt", conflict_cnt, 32'd4);
    chk("T3 i_grant_cnt", i_grant_cnt, 32'd3);
    chk("T3 d_grant_cnt", d_grant_cnt, 32'd3);

    // Write-back.
    push_req(32'h8000_0040, 1'b1, W1, 3, 1'b1);
    req_d(32'h8000_0040, 1'b1, 1'b0, W1);
    tick(3);
    chk("T4 d_grant_cnt", d_grant_cnt, 32'd4);
    chk("T4 i_grant_cnt", i_grant_cnt, 32'd3);

    // Reset in GRANT_I before l2_resp: request dropped, no i_resp.
    lat = 6;
    req_q.push_back('{addr: 32'h0000_6000, wr: 1'b0, wdata: 256'h0, len: 6});
    i_addr = 32'h0000_6000;
    i_read = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = l2_read;
    end
    chk("T5 l2_read raised", seen, 1'b1);
    tick(2);
    rst = 1'b1;
    #1;
    chk("T5 l2_read drops on rst", l2_read, 1'b0);
    chk("T5 be drops on rst", l2_byte_enable, 8'h00);
    chk("T5 no i_resp", i_resp, 1'b0);
    i_read = 1'b0;
    tick(2);
    chk("T5 i_grant_cnt", i_grant_cnt, 32'd0);
    chk("T5 d_grant_cnt", d_grant_cnt, 32'd0);
    chk("T5 conflict_cnt", conflict_cnt, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("T5 post-rst l2_read", l2_read, 1'b0);
    lat = 3;
    push_req(32'h0000_7000, 1'b0, 256'h0, 3, 1'b0);
    req_i(32'h0000_7005);
    tick(3);
    chk("T5 regrant i_grant_cnt", i_grant_cnt, 32'd1);

    // d_read & d_write together, then requester drops mid-transaction.
    lat = 4;
    push_req(32'h9000_0000, 1'b1, W2, 4, 1'b1);
    d_addr  = 32'h9000_001F;
    d_read  = 1'b1;
    d_write = 1'b1;
    d_wdata = W2;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = l2_write;
    end
    chk("T6 l2_write raised", seen, 1'b1);
    tick(1);
    d_read  = 1'b0;
    d_write = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = d_resp;
    end
    chk("T6 d_resp seen", seen, 1'b1);
    tick(6);
    chk("T6 d_grant_cnt", d_grant_cnt, 32'd1);

    chk("req queue drained", req_q.size(), 0);
    chk("resp queue drained", resp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
